wb_dcache_flush_ctrl: RTL and testbench
=======================================

Name: wb_dcache_flush_ctrl

Overview:
Sequencer for the write-back data cache's full-flush operation (fence / fence.i / debug entry). It runs on flush_i for the default 32 KiB, 8-way, 128-bit-line geometry (256 sets):
- walks every set;
- reads the valid and dirty state of all ways;
- issues one writeback request per dirty valid line;
- invalidates the set.

It competes with the miss handler for the tag array and the writeback port through request/grant handshakes, and reports completion to the controller.

Parameters:
NumSets, 256, number of cache sets walked.
NumWays, 8, associativity; width of the valid/dirty vectors.
IdxWidth, $clog2(NumSets), set index width.
WayWidth, $clog2(NumWays), way index width.
CntWidth, 16, width of the written-back line counter.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  start request; sampled only in IDLE
busy_o  out  1  high from the cycle after flush_i is accepted until DONE is left
flush_ack_o  out  1  one-cycle completion pulse
tag_req_o  out  1  tag/state array read request
tag_gnt_i  in  1  tag array grant
tag_idx_o  out  IdxWidth  set index being read
valid_i  in  NumWays  per-way valid bits; valid exactly 1 cycle after the tag grant
dirty_i  in  NumWays  per-way dirty bits; same timing as valid_i
wb_req_o  out  1  writeback request for a line
wb_gnt_i  in  1  writeback accepted
wb_idx_o  out  IdxWidth  set of the line to write back
wb_way_o  out  WayWidth  way of the line to write back
inv_req_o  out  1  invalidate-set request; clears valid and dirty in all ways
inv_gnt_i  in  1  invalidate accepted
inv_idx_o  out  IdxWidth  set to invalidate
wb_count_o  out  CntWidth  dirty lines written back in the current/last flush; saturating

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE, set index=0, pending mask=0, wb_count_o=0.
  - All req/ack/busy outputs are 0; index outputs are 0.
  - Reset mid-flush abandons the walk with no flush_ack_o.
- States: IDLE, TAG_REQ, TAG_WAIT, WRITEBACK, INVAL, DONE.
- IDLE:
  - flush_i=1 → set index=0, wb_count_o cleared, go to TAG_REQ.
  - flush_i in any other state is ignored; it is neither queued nor able to restart the walk.
- TAG_REQ:
  - tag_req_o=1, tag_idx_o=index.
  - Held until tag_gnt_i. On grant → TAG_WAIT.
- TAG_WAIT (1 cycle):
  - Capture pending = valid_i & dirty_i.
  - pending≠0 → WRITEBACK; otherwise → INVAL.
- WRITEBACK:
  - wb_req_o=1, wb_idx_o=index, wb_way_o=index of the lowest set bit of pending.
  - wb_req_o, wb_idx_o and wb_way_o stay stable until wb_gnt_i.
  - On grant: clear that bit and increment wb_count_o (saturating at all-ones).
  - If the cleared mask is 0 → INVAL; otherwise stay and present the next lowest way in the following cycle.
  - Exactly one line per grant.
- INVAL:
  - inv_req_o=1, inv_idx_o=index, held stable until inv_gnt_i.
  - On grant: if index==NumSets-1 → DONE; otherwise index+1 → TAG_REQ.
- DONE (1 cycle): flush_ack_o=1, busy_o=1, then → IDLE.
- busy_o=1 in every state except IDLE.
- At most one of tag_req_o, wb_req_o, inv_req_o is high in any cycle.
- Grants arriving while the matching request is low are ignored.
- Index arithmetic is unsigned IdxWidth. The terminal compare is against NumSets-1, so there is no wrap past the last set.
- Latency:
  - Clean set: 3 cycles with immediate grants (TAG_REQ, TAG_WAIT, INVAL).
  - Set with k dirty lines: 3+k cycles.
  - All-clean cache with immediate grants: 256×3+1 cycles from acceptance to the flush_ack_o pulse, inclusive.
- wb_count_o holds its value after DONE until the next accepted flush_i.

Test Plan:
1. All-clean cache, all grants tied high, pulse flush_i → tag_idx_o walks 0..255 in order, no wb_req_o, flush_ack_o pulses exactly once 769 cycles after acceptance, wb_count_o=0.
2. Set 5 with valid=8'hFF, dirty=8'b1010_0100 → wb_way_o sequence 2,5,7 at idx 5, then inv_req_o for idx 5; wb_count_o=3 at completion.
3. Set 9 with dirty=8'hFF but valid=8'h0F → writebacks only for ways 0..3; invalid dirty lines are skipped.
4. wb_gnt_i held low 10 cycles on set 0 way 3 → wb_req_o, wb_idx_o=0, wb_way_o=3 stable for all 10 cycles; no state advance; tag_req_o and inv_req_o stay low.
5. flush_i re-pulsed at set 100 mid-walk → ignored, walk continues to 255, single flush_ack_o; rst_ni asserted at set 50 → all outputs 0 immediately, no ack; a new flush then starts at idx 0.
6. Every set fully dirty (valid=dirty=8'hFF), CntWidth overridden to 4 → wb_count_o saturates at 15 while 2048 writebacks are issued.

Source files
------------

// File: rtl/wb_dcache_flush_ctrl.sv
// Full-flush sequencer for the write-back data cache: walks every set, writes back
// each valid+dirty line through the writeback port, then invalidates the set.
module wb_dcache_flush_ctrl #(
    parameter int unsigned NumSets  = 256,
    parameter int unsigned NumWays  = 8,
    parameter int unsigned IdxWidth = $clog2(NumSets),
    parameter int unsigned WayWidth = $clog2(NumWays),
    parameter int unsigned CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    output logic                busy_o,
    output logic                flush_ack_o,
    output logic                tag_req_o,
    input  logic                tag_gnt_i,
    output logic [IdxWidth-1:0] tag_idx_o,
    input  logic [NumWays-1:0]  valid_i,
    input  logic [NumWays-1:0]  dirty_i,
    output logic                wb_req_o,
    input  logic                wb_gnt_i,
    output logic [IdxWidth-1:0] wb_idx_o,
    output logic [WayWidth-1:0] wb_way_o,
    output logic                inv_req_o,
    input  logic                inv_gnt_i,
    output logic [IdxWidth-1:0] inv_idx_o,
    output logic [CntWidth-1:0] wb_count_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TAG_REQ,
        S_TAG_WAIT,
        S_WRITEBACK,
        S_INVAL,
        S_DONE
    } state_e;

    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumSets - 1);

    state_e              state_q, state_d;
    logic [IdxWidth-1:0] idx_q, idx_d;
    logic [NumWays-1:0]  pending_q, pending_d;
    logic [CntWidth-1:0] count_q, count_d;

    logic [NumWays-1:0]  line_hits;
    logic [NumWays-1:0]  pending_cleared;
    logic [WayWidth-1:0] low_way;

    assign line_hits = valid_i & dirty_i;

    // x & (x - 1) drops exactly the lowest set bit, i.e. the way just granted.
    assign pending_cleared = pending_q & (pending_q - NumWays'(1));

    // Lowest pending way; scanning downwards lets the last hit win.
    always_comb begin
        low_way = '0;
        for (int i = NumWays - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                low_way = WayWidth'(i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        count_d   = count_q;
        case (state_q)
            S_IDLE: begin
                if (flush_i) begin
                    state_d   = S_TAG_REQ;
                    idx_d     = '0;
                    pending_d = '0;
                    count_d   = '0;
                end
            end
            S_TAG_REQ: begin
                if (tag_gnt_i) begin
                    state_d = S_TAG_WAIT;
                end
            end
            S_TAG_WAIT: begin
                pending_d = line_hits;
                state_d   = (|line_hits) ? S_WRITEBACK : S_INVAL;
            end
            S_WRITEBACK: begin
                if (wb_gnt_i) begin
                    pending_d = pending_cleared;
                    if (count_q != '1) begin
                        count_d = count_q + CntWidth'(1);
                    end
                    if (pending_cleared == '0) begin
                        state_d = S_INVAL;
                    end
                end
            end
            S_INVAL: begin
                if (inv_gnt_i) begin
                    if (idx_q == LastIdx) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IdxWidth'(1);
                        state_d = S_TAG_REQ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Requests depend only on state, so each is naturally held until its grant.
    always_comb begin
        busy_o      = (state_q != S_IDLE);
        flush_ack_o = (state_q == S_DONE);
        tag_req_o   = (state_q == S_TAG_REQ);
        wb_req_o    = (state_q == S_WRITEBACK);
        inv_req_o   = (state_q == S_INVAL);
        tag_idx_o   = idx_q;
        wb_idx_o    = idx_q;
        inv_idx_o   = idx_q;
        wb_way_o    = low_way;
        wb_count_o  = count_q;
    end

endmodule

// File: tb/tb_wb_dcache_flush_ctrl.sv
// Randomized bench for wb_dcache_flush_ctrl: a cache-state array plays the tag array and
// the expected handshake stream per flush is derived from that array set by set.
module tb_wb_dcache_flush_ctrl;

    localparam int NS = 256;
    localparam int NW = 8;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        flush_i = 1'b0;
    logic        tag_gnt_i = 1'b0;
    logic        wb_gnt_i = 1'b0;
    logic        inv_gnt_i = 1'b0;
    logic [7:0]  valid_i = '0;
    logic [7:0]  dirty_i = '0;

    logic        busy_o, flush_ack_o, tag_req_o, wb_req_o, inv_req_o;
    logic [7:0]  tag_idx_o, wb_idx_o, inv_idx_o;
    logic [2:0]  wb_way_o;
    logic [15:0] wb_count_o;

    logic        s_busy, s_ack, s_tag_req, s_wb_req, s_inv_req;
    logic [7:0]  s_tag_idx, s_wb_idx, s_inv_idx;
    logic [2:0]  s_wb_way;
    logic [3:0]  s_count;

    wb_dcache_flush_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .busy_o(busy_o), .flush_ack_o(flush_ack_o),
        .tag_req_o(tag_req_o), .tag_gnt_i(tag_gnt_i), .tag_idx_o(tag_idx_o),
        .valid_i(valid_i), .dirty_i(dirty_i),
        .wb_req_o(wb_req_o), .wb_gnt_i(wb_gnt_i), .wb_idx_o(wb_idx_o), .wb_way_o(wb_way_o),
        .inv_req_o(inv_req_o), .inv_gnt_i(inv_gnt_i), .inv_idx_o(inv_idx_o),
        .wb_count_o(wb_count_o)
    );

    // Narrow-counter instance fed identical stimulus, used for saturation.
    wb_dcache_flush_ctrl #(.CntWidth(4)) dut_sat (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .busy_o(s_busy), .flush_ack_o(s_ack),
        .tag_req_o(s_tag_req), .tag_gnt_i(tag_gnt_i), .tag_idx_o(s_tag_idx),
        .valid_i(valid_i), .dirty_i(dirty_i),
        .wb_req_o(s_wb_req), .wb_gnt_i(wb_gnt_i), .wb_idx_o(s_wb_idx), .wb_way_o(s_wb_way),
        .inv_req_o(s_inv_req), .inv_gnt_i(inv_gnt_i), .inv_idx_o(s_inv_idx),
        .wb_count_o(s_count)
    );

    logic [7:0] mem_valid [NS];
    logic [7:0] mem_dirty [NS];

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ev(input int kind, input int idx, input int way);
        return kind * 4096 + idx * 16 + way;
    endfunction

    function automatic logic [63:0] all_outs();
        return {busy_o, flush_ack_o, tag_req_o, wb_req_o, inv_req_o,
                tag_idx_o, wb_idx_o, inv_idx_o, wb_way_o, wb_count_o,
                s_busy, s_ack, s_count};
    endfunction

    task automatic settle_idle(input int ncyc, input int exp_count);
        for (int c = 0; c < ncyc; c++) begin
            tag_gnt_i = 1'($urandom); wb_gnt_i = 1'($urandom); inv_gnt_i = 1'($urandom);
            valid_i = 8'($urandom); dirty_i = 8'($urandom);
            @(posedge clk_i); #1;
            check_val("idle_no_ack", {busy_o, flush_ack_o, tag_req_o, wb_req_o, inv_req_o}, 0);
            if (exp_count >= 0) check_val("count_hold", wb_count_o, exp_count);
        end
    endtask

    // One flush from an IDLE cycle (current time = posedge+1). Handshakes are compared
    // against the ordered stream TAG(s), WB(s,w) for each valid&dirty way ascending, INV(s).
    task automatic run_flush(input int gnt_pct, input int repulse_at, input int abort_at,
                             input bit stall_first, input int exp_lat);
        int  q[$];
        int  total, n, stall_cnt, cap_idx, exp_full, exp_sat;
        bit  done, cap, stall_done;
        bit  p_tag, p_wb, p_inv;
        logic [7:0] p_tidx, p_widx, p_iidx;
        logic [2:0] p_way;
        total = 0; n = 0; stall_cnt = 0; cap_idx = 0;
        done = 0; cap = 0; stall_done = 0;
        p_tag = 0; p_wb = 0; p_inv = 0;
        p_tidx = '0; p_widx = '0; p_iidx = '0; p_way = '0;
        for (int s = 0; s < NS; s++) begin
            q.push_back(ev(1, s, 0));
            for (int w = 0; w < NW; w++)
                if (mem_valid[s][w] && mem_dirty[s][w]) begin
                    q.push_back(ev(2, s, w));
                    total++;
                end
            q.push_back(ev(3, s, 0));
        end
        exp_full = (total > 65535) ? 65535 : total;
        exp_sat  = (total > 15) ? 15 : total;

        check_val("idle_before", busy_o, 0);
        flush_i = 1'b1;
        tag_gnt_i = 0; wb_gnt_i = 0; inv_gnt_i = 0;
        @(posedge clk_i); #1;
        n = 1;
        check_val("busy_after_accept", busy_o, 1);

        while (!done && n < 30000) begin
            flush_i = 1'b0;
            if (flush_ack_o) begin
                done = 1;
                if (exp_lat > 0) check_val("ack_latency", n, exp_lat);
                check_val("ack_busy", busy_o, 1);
                check_val("events_left", q.size(), 0);
                check_val("wb_count", wb_count_o, exp_full);
                check_val("wb_count_sat", s_count, exp_sat);
            end else begin
                check_val("busy", busy_o, 1);
                check_val("req_onehot", $countones({tag_req_o, wb_req_o, inv_req_o}) <= 1, 1);
                if (p_tag) check_val("tag_hold", {tag_req_o, tag_idx_o}, {1'b1, p_tidx});
                if (p_wb)  check_val("wb_hold", {wb_req_o, wb_idx_o, wb_way_o}, {1'b1, p_widx, p_way});
                if (p_inv) check_val("inv_hold", {inv_req_o, inv_idx_o}, {1'b1, p_iidx});

                tag_gnt_i = (int'($urandom_range(99)) < gnt_pct);
                wb_gnt_i  = (int'($urandom_range(99)) < gnt_pct);
                inv_gnt_i = (int'($urandom_range(99)) < gnt_pct);
                if (stall_first && !stall_done && wb_req_o) begin
                    wb_gnt_i = 1'b0;
                    stall_cnt++;
                    check_val("stall_others_low", {tag_req_o, inv_req_o}, 0);
                    if (stall_cnt == 10) stall_done = 1;
                end
                if (cap) begin
                    valid_i = mem_valid[cap_idx];
                    dirty_i = mem_dirty[cap_idx];
                end else begin
                    valid_i = 8'($urandom);
                    dirty_i = 8'($urandom);
                end
                cap = 0;

                if (tag_req_o && tag_gnt_i) begin
                    if (q.size() == 0) check_val("tag_hs_extra", 1, 0);
                    else check_val("tag_hs", ev(1, tag_idx_o, 0), q.pop_front());
                    cap = 1;
                    cap_idx = int'(tag_idx_o);
                    if (int'(tag_idx_o) == repulse_at) flush_i = 1'b1;
                    if (int'(tag_idx_o) == abort_at) begin
                        rst_ni = 1'b0;
                        #1;
                        check_val("abort_outs_zero", all_outs(), 0);
                        tag_gnt_i = 0; wb_gnt_i = 0; inv_gnt_i = 0;
                        repeat (2) @(posedge clk_i);
                        #1;
                        check_val("abort_held_zero", all_outs(), 0);
                        rst_ni = 1'b1;
                        settle_idle(5, 0);
                        return;
                    end
                end
                if (wb_req_o && wb_gnt_i) begin
                    if (q.size() == 0) check_val("wb_hs_extra", 1, 0);
                    else check_val("wb_hs", ev(2, wb_idx_o, wb_way_o), q.pop_front());
                end
                if (inv_req_o && inv_gnt_i) begin
                    if (q.size() == 0) check_val("inv_hs_extra", 1, 0);
                    else check_val("inv_hs", ev(3, inv_idx_o, 0), q.pop_front());
                    mem_valid[inv_idx_o] = '0;
                    mem_dirty[inv_idx_o] = '0;
                end
                p_tag = tag_req_o && !tag_gnt_i; p_tidx = tag_idx_o;
                p_wb  = wb_req_o && !wb_gnt_i;   p_widx = wb_idx_o; p_way = wb_way_o;
                p_inv = inv_req_o && !inv_gnt_i; p_iidx = inv_idx_o;
                @(posedge clk_i); #1;
                n++;
            end
        end
        if (!done) check_val("ack_timeout", 0, 1);
        if (stall_first) check_val("stall_cycles", stall_cnt, 10);
        settle_idle(4, exp_full);
        $display("flush done: wb_lines=%0d cycles=%0d count=%0d sat_count=%0d",
                 total, n, wb_count_o, s_count);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        for (int s = 0; s < NS; s++) begin
            mem_valid[s] = '0;
            mem_dirty[s] = '0;
        end
        #1;
        check_val("reset_outs", all_outs(), 0);
        repeat (3) @(posedge clk_i);
        #1;
        check_val("reset_outs_held", all_outs(), 0);
        rst_ni = 1'b1;
        settle_idle(2, 0);

        // All clean, grants always high: exact walk latency.
        run_flush(100, -1, -1, 1'b0, 769);

        // Directed sets: 0 (way 3 stalled), 5 (ways 2,5,7), 9 (only ways 0..3 valid).
        mem_valid[0] = 8'hFF; mem_dirty[0] = 8'h08;
        mem_valid[5] = 8'hFF; mem_dirty[5] = 8'hA4;
        mem_valid[9] = 8'h0F; mem_dirty[9] = 8'hFF;
        run_flush(60, -1, -1, 1'b1, 0);

        // Random contents with a flush re-pulse at set 100.
        for (int s = 0; s < NS; s++) begin
            mem_valid[s] = 8'($urandom);
            mem_dirty[s] = 8'($urandom & $urandom);
        end
        run_flush(70, 100, -1, 1'b0, 0);

        // Reset at set 50, then a fresh flush starting from set 0.
        for (int s = 0; s < NS; s++) begin
            mem_valid[s] = 8'($urandom);
            mem_dirty[s] = 8'($urandom & $urandom);
        end
        run_flush(80, -1, 50, 1'b0, 0);
        run_flush(80, -1, -1, 1'b0, 0);

        // Fully dirty cache: 2048 writebacks, narrow counter saturates.
        for (int s = 0; s < NS; s++) begin
            mem_valid[s] = 8'hFF;
            mem_dirty[s] = 8'hFF;
        end
        run_flush(75, -1, -1, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
